// File: rtl/register_file_bypass.sv
// -----------------------------------------------------------------------------
// register_file_bypass
//
// Purpose
//   A MIPS-style general purpose register file. It has one write port, a
//   dedicated link write for jal, HI/LO registers and a per-register pending
//   (busy) scoreboard. Reads are registered: the read data is captured on the
//   same rising edge that commits any write. A write in flight is forwarded to
//   a read of the same index, so a read never returns the stale value.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   rs, rt        read indices for the normal read path
//   rd_data_1/2   registered read data (one cycle latency)
//   wr_en         writeback enable
//   wr_addr       writeback index
//   wr_data       writeback data
//   jal           link write of pc_plus_4 into RA; also selects the link read
//   pc_plus_4     link value
//   syscall       selects (v0, a0) onto the read data
//   v0, a0        live contents of V0_IDX / A0_IDX (combinational)
//   hilo_wr       load hi_in / lo_in into hi / lo
//   hi_in, lo_in  HI / LO load values
//   hi, lo        HI / LO contents
//   issue_en      mark issue_addr as pending
//   issue_addr    destination being issued
//   busy_rs/rt    pending status of rs / rt as seen this cycle
// -----------------------------------------------------------------------------
module register_file_bypass #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                SP_IDX   = 29,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h7FFF_FFFC,
    parameter int                RA_IDX   = 31,
    parameter int                V0_IDX   = 2,
    parameter int                A0_IDX   = 4
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,

    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,

    input  logic              jal,
    input  logic [DATA_W-1:0] pc_plus_4,

    input  logic              syscall,
    output logic [DATA_W-1:0] v0,
    output logic [DATA_W-1:0] a0,

    input  logic              hilo_wr,
    input  logic [DATA_W-1:0] hi_in,
    input  logic [DATA_W-1:0] lo_in,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,

    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy_rs,
    output logic              busy_rt
);

    localparam int NREG = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0] RA_A = ADDR_W'(RA_IDX);
    localparam logic [ADDR_W-1:0] V0_A = ADDR_W'(V0_IDX);
    localparam logic [ADDR_W-1:0] A0_A = ADDR_W'(A0_IDX);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] regs      [NREG];
    logic [DATA_W-1:0] regs_next [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;

    // Per-index decode of this cycle's register writes and issues.
    logic              wr_hit;
    logic [NREG-1:0]   wr_clear;
    logic [NREG-1:0]   issue_set;

    logic [DATA_W-1:0] rd_next_1;
    logic [DATA_W-1:0] rd_next_2;

    // A write to index 0 is dropped entirely: no data, no busy effect.
    assign wr_hit = wr_en && (wr_addr != '0);

    // -------------------------------------------------------------------------
    // Next register state. regs_next is both the value committed at the edge
    // and the forwarding source for the read path, so the bypass and the
    // commit can never disagree. jal is applied last so it wins on RA.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_next[i] = regs[i];
            wr_clear[i]  = 1'b0;
            issue_set[i] = 1'b0;
            if (wr_hit && (wr_addr == ADDR_W'(i))) begin
                regs_next[i] = wr_data;
                wr_clear[i]  = 1'b1;
            end
            if (jal && (RA_A == ADDR_W'(i))) begin
                regs_next[i] = pc_plus_4;
                wr_clear[i]  = 1'b1;
            end
            if (issue_en && (issue_addr == ADDR_W'(i))) begin
                issue_set[i] = 1'b1;
            end
        end
        // Register 0 is hardwired to zero and never pending.
        regs_next[0] = '0;
        wr_clear[0]  = 1'b0;
        issue_set[0] = 1'b0;
    end

    // A set from issue overrides a clear from a completing write to the same
    // index: the newer producer is still outstanding.
    always_comb begin
        busy_next    = (busy & ~wr_clear) | issue_set;
        busy_next[0] = 1'b0;
    end

    // -------------------------------------------------------------------------
    // Read select: syscall > jal > normal, all reading through the bypass.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_next_1 = regs_next[rs];
        rd_next_2 = regs_next[rt];
        if (syscall) begin
            rd_next_1 = regs_next[V0_A];
            rd_next_2 = regs_next[A0_A];
        end else if (jal) begin
            rd_next_1 = pc_plus_4;
            rd_next_2 = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= regs_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_1 <= '0;
            rd_data_2 <= '0;
        end else begin
            rd_data_1 <= rd_next_1;
            rd_data_2 <= rd_next_2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_wr) begin
            hi <= hi_in;
            lo <= lo_in;
        end
    end

    // -------------------------------------------------------------------------
    // Combinational outputs
    // -------------------------------------------------------------------------
    assign v0 = regs[V0_A];
    assign a0 = regs[A0_A];

    // busy & busy_next drops an index that a write is clearing this cycle,
    // but keeps it when an issue to the same index re-arms it. busy[0] is
    // never set, so index 0 always reads as not pending.
    assign busy_rs = busy[rs] & busy_next[rs];
    assign busy_rt = busy[rt] & busy_next[rt];

endmodule

// File: tb/tb_register_file_bypass.sv
// -----------------------------------------------------------------------------
// tb_register_file_bypass
//
// Directed bench for register_file_bypass. Inputs change one time unit after
// a rising edge; registered outputs are sampled one time unit after the edge
// they were captured on, combinational outputs just before the next edge.
// -----------------------------------------------------------------------------
module tb_register_file_bypass;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [31:0] SP_VAL = 32'h7FFF_FFFC;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] rd_data_1;
    logic [DATA_W-1:0] rd_data_2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              jal;
    logic [DATA_W-1:0] pc_plus_4;
    logic              syscall;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] a0;
    logic              hilo_wr;
    logic [DATA_W-1:0] hi_in;
    logic [DATA_W-1:0] lo_in;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;
    logic              busy_rs;
    logic              busy_rt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_q[$];

    register_file_bypass dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rs         (rs),
        .rt         (rt),
        .rd_data_1  (rd_data_1),
        .rd_data_2  (rd_data_2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .jal        (jal),
        .pc_plus_4  (pc_plus_4),
        .syscall    (syscall),
        .v0         (v0),
        .a0         (a0),
        .hilo_wr    (hilo_wr),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .hi         (hi),
        .lo         (lo),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .busy_rs    (busy_rs),
        .busy_rt    (busy_rt)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- drivers
    task automatic idle();
        rs = '0; rt = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        jal = 1'b0; pc_plus_4 = '0;
        syscall = 1'b0;
        hilo_wr = 1'b0; hi_in = '0; lo_in = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read rs/rt with no writes; results are valid after return.
    task automatic read_regs(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        idle();
        rs = a;
        rt = b;
        step();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        #12;
        n_cmp++; if (rd_data_1 !== 32'h0) begin n_err++; $display("FAIL reset_rd1 got %h exp %h", rd_data_1, 32'h0); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL reset_hilo got %h/%h exp 0/0", hi, lo); end
        n_cmp++; if (v0 !== 32'h0 || a0 !== 32'h0) begin n_err++; $display("FAIL reset_v0a0 got %h/%h exp 0/0", v0, a0); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        rs = 5'd29;
        rt = 5'd0;
        #1;
        n_cmp++; if (busy_rs !== 1'b0) begin n_err++; $display("FAIL reset_busy_rs got %b exp 0", busy_rs); end
        step();
        n_cmp++; if (rd_data_1 !== SP_VAL) begin n_err++; $display("FAIL reset_sp got %h exp %h", rd_data_1, SP_VAL); end
        n_cmp++; if (rd_data_2 !== 32'h0) begin n_err++; $display("FAIL reset_r0 got %h exp %h", rd_data_2, 32'h0); end
    endtask

    task automatic test_write_bypass();
        idle();
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEAD_BEEF;
        rs = 5'd8; rt = 5'd29;
        step();
        n_cmp++; if (rd_data_1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bypass_rs got %h exp %h", rd_data_1, 32'hDEAD_BEEF); end
        n_cmp++; if (rd_data_2 !== SP_VAL) begin n_err++; $display("FAIL bypass_rt_other got %h exp %h", rd_data_2, SP_VAL); end
        read_regs(5'd0, 5'd8);
        n_cmp++; if (rd_data_2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL stored_r8 got %h exp %h", rd_data_2, 32'hDEAD_BEEF); end
        // Write to register 0 is discarded, including on the bypass path.
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        rs = 5'd0;
        step();
        n_cmp++; if (rd_data_1 !== 32'h0) begin n_err++; $display("FAIL r0_bypass got %h exp %h", rd_data_1, 32'h0); end
        read_regs(5'd0, 5'd0);
        n_cmp++; if (rd_data_1 !== 32'h0) begin n_err++; $display("FAIL r0_stored got %h exp %h", rd_data_1, 32'h0); end
    endtask

    task automatic test_jal();
        idle();
        jal = 1'b1; pc_plus_4 = 32'h0040_0010;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h5;
        rs = 5'd8; rt = 5'd8;
        step();
        n_cmp++; if (rd_data_1 !== 32'h0040_0010) begin n_err++; $display("FAIL jal_rd1 got %h exp %h", rd_data_1, 32'h0040_0010); end
        n_cmp++; if (rd_data_2 !== 32'h0) begin n_err++; $display("FAIL jal_rd2 got %h exp %h", rd_data_2, 32'h0); end
        read_regs(5'd31, 5'd8);
        n_cmp++; if (rd_data_1 !== 32'h0040_0010) begin n_err++; $display("FAIL jal_ra_wins got %h exp %h", rd_data_1, 32'h0040_0010); end
    endtask

    task automatic test_syscall();
        idle();
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd10;
        step();
        n_cmp++; if (v0 !== 32'd10) begin n_err++; $display("FAIL v0_live got %h exp %h", v0, 32'd10); end
        idle();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd7;
        step();
        n_cmp++; if (a0 !== 32'd7) begin n_err++; $display("FAIL a0_live got %h exp %h", a0, 32'd7); end
        idle();
        syscall = 1'b1; rs = 5'd8; rt = 5'd31;
        step();
        n_cmp++; if (rd_data_1 !== 32'd10) begin n_err++; $display("FAIL sys_rd1 got %h exp %h", rd_data_1, 32'd10); end
        n_cmp++; if (rd_data_2 !== 32'd7) begin n_err++; $display("FAIL sys_rd2 got %h exp %h", rd_data_2, 32'd7); end
        // syscall outranks jal on the read select.
        idle();
        syscall = 1'b1; jal = 1'b1; pc_plus_4 = 32'h0040_0100;
        step();
        n_cmp++; if (rd_data_1 !== 32'd10 || rd_data_2 !== 32'd7) begin n_err++; $display("FAIL sys_over_jal got %h/%h exp %h/%h", rd_data_1, rd_data_2, 32'd10, 32'd7); end
        // syscall forwards a same-cycle write to v0.
        idle();
        syscall = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd11;
        step();
        n_cmp++; if (rd_data_1 !== 32'd11) begin n_err++; $display("FAIL sys_bypass got %h exp %h", rd_data_1, 32'd11); end
    endtask

    task automatic test_hold();
        // Garbage on the data inputs with every enable low changes nothing.
        idle();
        wr_addr = 5'd8; wr_data = 32'hFFFF_FFFF;
        hi_in = 32'hAAAA_AAAA; lo_in = 32'h5555_5555;
        issue_addr = 5'd8;
        rs = 5'd8; rt = 5'd31;
        step();
        step();
        n_cmp++; if (rd_data_1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL hold_r8 got %h exp %h", rd_data_1, 32'hDEAD_BEEF); end
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL hold_hilo got %h/%h exp 0/0", hi, lo); end
        n_cmp++; if (busy_rs !== 1'b0) begin n_err++; $display("FAIL hold_busy got %b exp 0", busy_rs); end
    endtask

    task automatic test_scoreboard();
        idle();
        issue_en = 1'b1; issue_addr = 5'd9;
        step();
        idle();
        rs = 5'd9; rt = 5'd10;
        #1;
        n_cmp++; if (busy_rs !== 1'b1) begin n_err++; $display("FAIL sb_set got %b exp 1", busy_rs); end
        n_cmp++; if (busy_rt !== 1'b0) begin n_err++; $display("FAIL sb_other got %b exp 0", busy_rt); end
        // Write and issue to the same index: issue wins.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        issue_en = 1'b1; issue_addr = 5'd9;
        #1;
        n_cmp++; if (busy_rs !== 1'b1) begin n_err++; $display("FAIL sb_issue_wins_comb got %b exp 1", busy_rs); end
        step();
        idle();
        rs = 5'd9;
        #1;
        n_cmp++; if (busy_rs !== 1'b1) begin n_err++; $display("FAIL sb_issue_wins got %b exp 1", busy_rs); end
        // Plain write clears, visible combinationally in the same cycle.
        rt = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9A;
        #1;
        n_cmp++; if (busy_rs !== 1'b0 || busy_rt !== 1'b0) begin n_err++; $display("FAIL sb_clear_comb got %b/%b exp 0/0", busy_rs, busy_rt); end
        step();
        idle();
        rs = 5'd9;
        #1;
        n_cmp++; if (busy_rs !== 1'b0) begin n_err++; $display("FAIL sb_cleared got %b exp 0", busy_rs); end
        // Issue to index 0 never marks it pending.
        idle();
        issue_en = 1'b1; issue_addr = 5'd0;
        step();
        idle();
        rs = 5'd0;
        #1;
        n_cmp++; if (busy_rs !== 1'b0) begin n_err++; $display("FAIL sb_r0 got %b exp 0", busy_rs); end
        // jal completes the RA producer.
        idle();
        issue_en = 1'b1; issue_addr = 5'd31;
        step();
        idle();
        jal = 1'b1; pc_plus_4 = 32'h0040_0020;
        step();
        idle();
        rt = 5'd31;
        #1;
        n_cmp++; if (busy_rt !== 1'b0) begin n_err++; $display("FAIL sb_jal_clear got %b exp 0", busy_rt); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] vals [4];
        vals[0] = 32'h0000_0001;
        vals[1] = 32'hFFFF_FFFF;
        vals[2] = 32'h8000_0000;
        vals[3] = 32'h1357_9BDF;
        // Consecutive writes, each forwarded to its own read on the same edge.
        for (int i = 0; i < 4; i++) begin
            idle();
            wr_en = 1'b1; wr_addr = ADDR_W'(16 + i); wr_data = vals[i];
            rt = ADDR_W'(16 + i);
            exp_q.push_back(vals[i]);
            step();
            n_cmp++; if (rd_data_2 !== vals[i]) begin n_err++; $display("FAIL b2b_bypass%0d got %h exp %h", i, rd_data_2, vals[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            logic [DATA_W-1:0] e;
            read_regs(ADDR_W'(16 + i), 5'd0);
            e = exp_q.pop_front();
            n_cmp++; if (rd_data_1 !== e) begin n_err++; $display("FAIL b2b_read%0d got %h exp %h", i, rd_data_1, e); end
        end
    endtask

    task automatic test_hilo_reset();
        idle();
        hilo_wr = 1'b1; hi_in = 32'd3; lo_in = 32'd4;
        issue_en = 1'b1; issue_addr = 5'd12;
        step();
        n_cmp++; if (hi !== 32'd3 || lo !== 32'd4) begin n_err++; $display("FAIL hilo_load got %h/%h exp 3/4", hi, lo); end
        // Mid-cycle reset with a write in flight.
        idle();
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h0000_0042;
        rs = 5'd12;
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL rst_hilo got %h/%h exp 0/0", hi, lo); end
        n_cmp++; if (busy_rs !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy_rs); end
        n_cmp++; if (rd_data_1 !== 32'h0) begin n_err++; $display("FAIL rst_rd got %h exp 0", rd_data_1); end
        n_cmp++; if (v0 !== 32'h0) begin n_err++; $display("FAIL rst_v0 got %h exp 0", v0); end
        // Edges while held in reset do nothing.
        hilo_wr = 1'b1; hi_in = 32'd9; lo_in = 32'd9;
        step();
        step();
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL rst_held_hi got %h exp 0", hi); end
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        #1;
        read_regs(5'd29, 5'd8);
        n_cmp++; if (rd_data_1 !== SP_VAL) begin n_err++; $display("FAIL rst_sp got %h exp %h", rd_data_1, SP_VAL); end
        n_cmp++; if (rd_data_2 !== 32'h0) begin n_err++; $display("FAIL rst_r8_discard got %h exp 0", rd_data_2); end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        idle();
        reset_n = 1'b1;
        test_reset();
        test_write_bypass();
        test_jal();
        test_syscall();
        test_hold();
        test_scoreboard();
        test_back_to_back();
        test_hilo_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
